// File: rtl/fetch_unit.sv
// fetch_unit: instruction fetch sequencer for a single-issue core.
//   Fetches one word from instruction memory at PC, presents it to the
//   decoder until the datapath commits it, then advances PC using the
//   decoder's next-PC select (plus4 / branch / jump).
// Ports:
//   clk, rst             clock, asynchronous active-high reset
//   imem_req/imem_addr   fetch request and word-aligned address (to memory)
//   imem_rdata/imem_ack  fetched word and completion strobe (from memory)
//   instr_valid, instr   latched instruction for the decoder
//   Op, Funct, PC        instr[31:26], instr[5:0], address of instr
//   NPCOp, exec_done     next-PC select and commit strobe (from datapath)
//   retired              committed-instruction counter (wraps)
//   fetch_err            sticky fetch timeout flag
// Build option: define FETCH_UNIT_TIMEOUT_EN to enable the fetch watchdog
//   (ERR state, fetch_err); otherwise FETCH waits indefinitely for ack.
module fetch_unit #(
  parameter logic [31:0] RESET_PC       = 32'h0000_3000,
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic        clk,
  input  logic        rst,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic [31:0] imem_rdata,
  input  logic        imem_ack,
  output logic        instr_valid,
  output logic [31:0] instr,
  output logic [5:0]  Op,
  output logic [5:0]  Funct,
  output logic [31:0] PC,
  input  logic [1:0]  NPCOp,
  input  logic        exec_done,
  output logic [31:0] retired,
  output logic        fetch_err
);

  localparam int unsigned XLEN = 32;
  localparam int unsigned CW   = 8;
  localparam logic [XLEN-1:0] PC_RST = {RESET_PC[XLEN-1:2], 2'b00};

  // Watchdog limit must fit the 8-bit counter and be non-zero.
  if (TIMEOUT_CYCLES < 1 || TIMEOUT_CYCLES > 255) begin : g_bad_timeout
    $error("fetch_unit: TIMEOUT_CYCLES must be in 1..255");
  end

  typedef enum logic [1:0] {
    FETCH = 2'd0,
    ISSUE = 2'd1,
    ERR   = 2'd2
  } state_e;

  state_e            state_q, state_d;
  logic [XLEN-1:0]   pc_q, pc_d;
  logic [XLEN-1:0]   instr_q, instr_d;
  logic [XLEN-1:0]   ret_q, ret_d;
  logic              req_q, req_d;
  logic              valid_q, valid_d;
  logic [XLEN-1:0]   pc_plus4;
  logic [XLEN-1:0]   br_off;
  logic [XLEN-1:0]   npc;

`ifdef FETCH_UNIT_TIMEOUT_EN
  localparam logic [CW-1:0] TO_LIMIT = CW'(TIMEOUT_CYCLES);
  logic [CW-1:0] cnt_q, cnt_d;
  logic [CW-1:0] cnt_inc;
  logic          err_q, err_d;
`endif

  // Next-PC selection; reserved encoding behaves as plus4.
  always_comb begin
    pc_plus4 = pc_q + 32'd4;
    br_off   = {{14{instr_q[15]}}, instr_q[15:0], 2'b00};
    case (NPCOp)
      2'b01:   npc = pc_plus4 + br_off;
      2'b10:   npc = {pc_plus4[31:28], instr_q[25:0], 2'b00};
      default: npc = pc_plus4;
    endcase
  end

  // Next-state and register update logic.
  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    instr_d = instr_q;
    ret_d   = ret_q;
    req_d   = req_q;
    valid_d = valid_q;
`ifdef FETCH_UNIT_TIMEOUT_EN
    cnt_d   = cnt_q;
    err_d   = err_q;
    cnt_inc = cnt_q + CW'(1);
`endif
    case (state_q)
      FETCH: begin
        // req_q is low only in the first cycle after reset; an ack there
        // answers no request and is ignored.
        req_d   = 1'b1;
        valid_d = 1'b0;
        if (req_q && imem_ack) begin
          instr_d = imem_rdata;
          state_d = ISSUE;
          req_d   = 1'b0;
          valid_d = 1'b1;
`ifdef FETCH_UNIT_TIMEOUT_EN
          cnt_d   = '0;
`endif
        end
`ifdef FETCH_UNIT_TIMEOUT_EN
        else if (req_q) begin
          if (cnt_inc == TO_LIMIT) begin
            state_d = ERR;
            req_d   = 1'b0;
            err_d   = 1'b1;
            cnt_d   = '0;
          end else begin
            cnt_d = cnt_inc;
          end
        end
`endif
      end
      ISSUE: begin
        req_d   = 1'b0;
        valid_d = 1'b1;
        if (exec_done) begin
          pc_d    = npc;
          ret_d   = ret_q + 32'd1;
          state_d = FETCH;
          req_d   = 1'b1;
          valid_d = 1'b0;
        end
      end
`ifdef FETCH_UNIT_TIMEOUT_EN
      ERR: begin
        req_d   = 1'b0;
        valid_d = 1'b0;
        err_d   = 1'b1;
      end
`endif
      default: begin
        state_d = FETCH;
        req_d   = 1'b0;
        valid_d = 1'b0;
      end
    endcase
  end

  // State and datapath registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= FETCH;
      pc_q    <= PC_RST;
      instr_q <= '0;
      ret_q   <= '0;
      req_q   <= 1'b0;
      valid_q <= 1'b0;
`ifdef FETCH_UNIT_TIMEOUT_EN
      cnt_q   <= '0;
      err_q   <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      pc_q    <= {pc_d[XLEN-1:2], 2'b00};
      instr_q <= instr_d;
      ret_q   <= ret_d;
      req_q   <= req_d;
      valid_q <= valid_d;
`ifdef FETCH_UNIT_TIMEOUT_EN
      cnt_q   <= cnt_d;
      err_q   <= err_d;
`endif
    end
  end

  assign imem_req    = req_q;
  assign imem_addr   = pc_q;
  assign instr_valid = valid_q;
  assign instr       = instr_q;
  assign Op          = instr_q[31:26];
  assign Funct       = instr_q[5:0];
  assign PC          = pc_q;
  assign retired     = ret_q;
`ifdef FETCH_UNIT_TIMEOUT_EN
  assign fetch_err   = err_q;
`else
  assign fetch_err   = 1'b0;
`endif

endmodule

// File: tb/tb_fetch_unit.sv
// tb_fetch_unit: scoreboard bench for fetch_unit. Stimulus pushes expected
// fetch addresses and issued instructions into queues; a monitor pops and
// compares when the DUT raises imem_req or instr_valid.
module tb_fetch_unit;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] instr;
    logic [31:0] ret;
  } iss_t;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic [31:0] imem_rdata = '0;
  logic        imem_ack = 1'b0;
  logic        instr_valid;
  logic [31:0] instr;
  logic [5:0]  Op;
  logic [5:0]  Funct;
  logic [31:0] PC;
  logic [1:0]  NPCOp = 2'b00;
  logic        exec_done = 1'b0;
  logic [31:0] retired;
  logic        fetch_err;

  fetch_unit dut (
    .clk(clk), .rst(rst),
    .imem_req(imem_req), .imem_addr(imem_addr),
    .imem_rdata(imem_rdata), .imem_ack(imem_ack),
    .instr_valid(instr_valid), .instr(instr), .Op(Op), .Funct(Funct),
    .PC(PC), .NPCOp(NPCOp), .exec_done(exec_done),
    .retired(retired), .fetch_err(fetch_err)
  );

  always #5 clk = ~clk;

  logic [31:0] addr_q[$];
  iss_t        iss_q[$];
  int          n_chk  = 0;
  int          n_fail = 0;

  function automatic void chk(string name, logic [31:0] act, logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endfunction

  // Monitor: sampled 1 time unit after each rising edge.
  logic        req_prev = 1'b0;
  logic        valid_prev = 1'b0;
  logic [31:0] addr_prev = '0;
  logic [31:0] instr_hold = '0;
  logic [31:0] pc_hold = '0;
  iss_t        exp_iss;

  always @(posedge clk) begin
    #1;
    if (!rst) begin
      if (req_prev && imem_ack)
        chk("ack_to_valid", 32'(instr_valid), 32'd1);
      if (imem_req && !req_prev) begin
        if (addr_q.size() == 0) begin
          n_chk++; n_fail++;
          $display("FAIL fetch_unexpected: got addr %h expected no request", imem_addr);
        end else begin
          chk("fetch_addr", imem_addr, addr_q.pop_front());
        end
      end else if (imem_req && req_prev) begin
        chk("addr_stable", imem_addr, addr_prev);
      end
      if (instr_valid && !valid_prev) begin
        if (iss_q.size() == 0) begin
          n_chk++; n_fail++;
          $display("FAIL issue_unexpected: got instr %h expected no issue", instr);
        end else begin
          exp_iss = iss_q.pop_front();
          chk("issue_pc", PC, exp_iss.pc);
          chk("issue_instr", instr, exp_iss.instr);
          chk("issue_op", 32'(Op), 32'(exp_iss.instr[31:26]));
          chk("issue_funct", 32'(Funct), 32'(exp_iss.instr[5:0]));
          chk("issue_retired", retired, exp_iss.ret);
        end
      end else if (instr_valid && valid_prev) begin
        chk("hold_instr", instr, instr_hold);
        chk("hold_pc", PC, pc_hold);
      end
    end
    req_prev   = imem_req;
    valid_prev = instr_valid;
    addr_prev  = imem_addr;
    instr_hold = instr;
    pc_hold    = PC;
  end

  task automatic expect_fetch(input logic [31:0] a, input logic [31:0] ins,
                              input logic [31:0] r, input bit issue);
    iss_t it;
    addr_q.push_back(a);
    if (issue) begin
      it.pc = a; it.instr = ins; it.ret = r;
      iss_q.push_back(it);
    end
  endtask

  // Answer the pending request after 'delay' idle request cycles; called at a negedge.
  task automatic serve(input int delay, input logic [31:0] data, input bit noise);
    int n = 0;
    while (!imem_req && n < 20) begin
      @(negedge clk);
      n++;
    end
    if (!imem_req) begin
      n_chk++; n_fail++;
      $display("FAIL serve_wait: got imem_req 0 expected 1 within 20 cycles");
      return;
    end
    repeat (delay) begin
      exec_done  = noise;
      NPCOp      = 2'b01;
      imem_rdata = $urandom;
      @(negedge clk);
    end
    exec_done  = 1'b0;
    imem_ack   = 1'b1;
    imem_rdata = data;
    @(negedge clk);
    imem_ack   = 1'b0;
    imem_rdata = 32'hDEAD_BEEF;
  endtask

  task automatic retire(input logic [1:0] op);
    int n = 0;
    while (!instr_valid && n < 20) begin
      @(negedge clk);
      n++;
    end
    if (!instr_valid) begin
      n_chk++; n_fail++;
      $display("FAIL retire_wait: got instr_valid 0 expected 1 within 20 cycles");
      return;
    end
    NPCOp     = op;
    exec_done = 1'b1;
    @(negedge clk);
    exec_done = 1'b0;
    NPCOp     = 2'b10;
  endtask

  initial begin
    #100000;
    $display("FAIL global_timeout: got no finish expected finish by 100000");
    $fatal(1, "timeout");
  end

  initial begin
    // Reset state, with stray ack/exec_done while in reset.
    repeat (2) @(negedge clk);
    imem_ack = 1'b1; exec_done = 1'b1;
    @(negedge clk);
    imem_ack = 1'b0; exec_done = 1'b0;
    chk("reset_req", 32'(imem_req), 32'd0);
    chk("reset_valid", 32'(instr_valid), 32'd0);
    chk("reset_pc", PC, 32'h0000_3000);
    chk("reset_instr", instr, 32'd0);
    chk("reset_retired", retired, 32'd0);
    chk("reset_err", 32'(fetch_err), 32'd0);

    // First fetch acked in its first request cycle.
    expect_fetch(32'h0000_3000, 32'h2008_0005, 32'd0, 1'b1);
    rst = 1'b0;
    serve(0, 32'h2008_0005, 1'b0);
    // Stray ack while issuing must not disturb the held instruction.
    imem_ack = 1'b1; imem_rdata = 32'hFFFF_FFFF;
    @(negedge clk);
    imem_ack = 1'b0;
    @(negedge clk);

    expect_fetch(32'h0000_3004, 32'h0800_0C04, 32'd1, 1'b1);
    retire(2'b00);
    serve(5, 32'h0800_0C04, 1'b1);                           // delayed ack, exec_done noise
    expect_fetch(32'h0000_3010, 32'h1000_FFFE, 32'd2, 1'b1);
    retire(2'b10);                                           // jump to 0x3010
    serve(2, 32'h1000_FFFE, 1'b0);
    expect_fetch(32'h0000_300C, 32'h0800_0C10, 32'd3, 1'b1);
    retire(2'b01);                                           // branch -2 words
    serve(1, 32'h0800_0C10, 1'b0);
    expect_fetch(32'h0000_3040, 32'h0000_0020, 32'd4, 1'b1);
    retire(2'b10);                                           // jump to 0x3040
    serve(0, 32'h0000_0020, 1'b0);
    expect_fetch(32'h0000_3044, 32'h8C01_0004, 32'd5, 1'b1);
    retire(2'b11);                                           // reserved -> plus4
    serve(3, 32'h8C01_0004, 1'b1);
    expect_fetch(32'h0000_3058, 32'hABCD_1234, 32'd6, 1'b1);
    retire(2'b01);                                           // branch +4 words
    serve(0, 32'hABCD_1234, 1'b0);

    // Reset in the middle of ISSUE.
    @(negedge clk);
    rst = 1'b1;
    #1;
    chk("mi_valid", 32'(instr_valid), 32'd0);
    chk("mi_req", 32'(imem_req), 32'd0);
    chk("mi_pc", PC, 32'h0000_3000);
    chk("mi_retired", retired, 32'd0);

    // Reset in the middle of a fetch, with an ack arriving at the same time.
    expect_fetch(32'h0000_3000, 32'd0, 32'd0, 1'b0);
    @(negedge clk);
    rst = 1'b0;
    repeat (2) @(negedge clk);
    chk("mf_req_up", 32'(imem_req), 32'd1);
    imem_ack = 1'b1; imem_rdata = 32'h1234_5678;
    rst = 1'b1;
    #1;
    chk("mf_req", 32'(imem_req), 32'd0);
    chk("mf_pc", PC, 32'h0000_3000);
    chk("mf_retired", retired, 32'd0);
    @(negedge clk);
    imem_ack = 1'b0;
    chk("mf_instr", instr, 32'd0);
    chk("mf_valid", 32'(instr_valid), 32'd0);

    // Reserved NPCOp from 0x3000.
    expect_fetch(32'h0000_3000, 32'h0800_0C10, 32'd0, 1'b1);
    rst = 1'b0;
    serve(0, 32'h0800_0C10, 1'b0);
    expect_fetch(32'h0000_3004, 32'd0, 32'd1, 1'b0);
    retire(2'b11);

    // Unanswered fetch.
    repeat (300) @(negedge clk);
`ifdef FETCH_UNIT_TIMEOUT_EN
    chk("to_err", 32'(fetch_err), 32'd1);
    chk("to_req", 32'(imem_req), 32'd0);
    imem_ack = 1'b1; imem_rdata = 32'h2008_0005;
    repeat (2) @(negedge clk);
    imem_ack = 1'b0;
    chk("to_err_sticky", 32'(fetch_err), 32'd1);
    chk("to_valid", 32'(instr_valid), 32'd0);
    chk("to_req_low", 32'(imem_req), 32'd0);
`else
    chk("to_req", 32'(imem_req), 32'd1);
    chk("to_addr", imem_addr, 32'h0000_3004);
    chk("to_err", 32'(fetch_err), 32'd0);
    chk("to_valid", 32'(instr_valid), 32'd0);
`endif
    rst = 1'b1;
    #1;
    chk("final_err", 32'(fetch_err), 32'd0);
    chk("final_req", 32'(imem_req), 32'd0);
    chk("addr_q_empty", 32'(addr_q.size()), 32'd0);
    chk("iss_q_empty", 32'(iss_q.size()), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/fetch_unit.md
FETCH_UNIT -- requirements
Module: fetch_unit

Interface
REQ-001 SHALL have parameter RESET_PC, default 32'h0000_3000, first instruction address after reset.
REQ-002 SHALL have parameter TIMEOUT_CYCLES, default 255, fetch-acknowledge wait limit (8-bit range, 1..255).
REQ-003 SHALL have one clock; reset is asynchronous and active-high (ports clk, rst).
REQ-004 clk  input  1  rising-edge clock.
REQ-005 rst  input  1  asynchronous active-high reset.
REQ-006 imem_req  output  1  instruction fetch request.
REQ-007 imem_addr  output  32  fetch address, word aligned.
REQ-008 imem_rdata  input  32  fetched instruction word.
REQ-009 imem_ack  input  1  fetch complete; imem_rdata valid this cycle.
REQ-010 instr_valid  output  1  instr/Op/Funct/PC hold a valid instruction for the decoder.
REQ-011 instr  output  32  latched instruction word.
REQ-012 Op  output  6  instr[31:26], to the control decoder.
REQ-013 Funct  output  6  instr[5:0], to the control decoder.
REQ-014 PC  output  32  address of the latched instruction.
REQ-015 NPCOp  input  2  next-PC select from the control decoder: 00 plus4, 01 branch, 10 jump, 11 reserved.
REQ-016 exec_done  input  1  datapath has committed the current instruction.
REQ-017 retired  output  32  count of committed instructions.
REQ-018 fetch_err  output  1  sticky fetch timeout flag (REQ-040 build only).

Function
REQ-019 SHALL implement states FETCH, ISSUE, ERR; ERR reachable only when the REQ-040 macro is defined.
REQ-020 FETCH: imem_req=1, imem_addr=PC; on imem_ack, latch imem_rdata into instr and go to ISSUE next edge.
REQ-021 imem_req and imem_addr SHALL stay stable from assertion until the imem_ack cycle inclusive.
REQ-022 Ack in the first request cycle SHALL be accepted; minimum fetch latency = 1 cycle, instr_valid rises the following cycle.
REQ-023 ISSUE: instr_valid=1, imem_req=0; instr, Op, Funct, PC SHALL hold constant until exec_done.
REQ-024 On exec_done in ISSUE: PC <= NPC, retired <= retired+1, state <= FETCH next edge.
REQ-025 NPC for 00 and 11: PC+4.
REQ-026 NPC for 01: PC+4 + (sign-extended instr[15:0] << 2), modulo 2^32.
REQ-027 NPC for 10: {(PC+4)[31:28], instr[25:0], 2'b00}.
REQ-028 NPCOp SHALL be sampled only in the exec_done cycle; other cycles ignored.
REQ-029 imem_ack outside FETCH and exec_done outside ISSUE SHALL be ignored.
REQ-030 PC[1:0] SHALL always be 00; RESET_PC[1:0] forced to 00.
REQ-031 retired SHALL wrap 32'hFFFF_FFFF -> 0 without flag.
REQ-032 Op and Funct SHALL be pure slices of the instr register (no extra latency).

Reset
REQ-033 rst SHALL asynchronously force state FETCH, PC=RESET_PC, instr=0, retired=0, fetch_err=0, timeout counter=0.
REQ-034 During rst: imem_req=0, instr_valid=0; imem_req SHALL rise on the first clock edge after rst deasserts.
REQ-035 rst mid-fetch SHALL drop imem_req immediately and discard any outstanding ack.
REQ-036 rst mid-ISSUE SHALL discard the instruction without incrementing retired.

Configuration
REQ-037 Macro FETCH_UNIT_TIMEOUT_EN SHALL select the fetch watchdog.
REQ-038 Defined: 8-bit counter increments each FETCH cycle without imem_ack, clears on ack or state exit.
REQ-039 Defined: counter reaching TIMEOUT_CYCLES without ack SHALL move to ERR next edge.
REQ-040 ERR: imem_req=0, instr_valid=0, fetch_err=1, exit only by rst.
REQ-041 Undefined: no counter, no ERR state, fetch_err tied 0, FETCH waits indefinitely.

Verification
REQ-042 Reset, ack in first req cycle, rdata 32'h2008_0005 -> imem_addr 32'h0000_3000; next cycle instr_valid=1, Op=6'h08, PC=32'h0000_3000.
REQ-043 Ack delayed 5 cycles -> imem_req high, imem_addr constant all 6 cycles; instr_valid exactly one cycle after ack.
REQ-044 PC 32'h0000_3010, instr 32'h1000_FFFE, exec_done with NPCOp=01 -> next imem_addr 32'h0000_300C; retired+1.
REQ-045 PC 32'h0000_3000, instr 32'h0800_0C10, NPCOp=10 -> next imem_addr 32'h0000_3040; NPCOp=11 -> 32'h0000_3004.
REQ-046 rst asserted mid-fetch and mid-ISSUE -> imem_req/instr_valid 0 same cycle, PC 32'h0000_3000, retired unchanged 0.
REQ-047 With FETCH_UNIT_TIMEOUT_EN, no ack for 255 cycles -> fetch_err=1, imem_req=0 thereafter; later ack ignored until rst.
